fpu_alu_arbiter: RTL and testbench
==================================

# fpu_alu_arbiter

- Shares one sign-magnitude integer add/subtract datapath between two requesters, for example the mantissa adder path and the rounding/normalise path of the FPU.
- Each requester uses a valid/ready handshake. The arbiter grants in round-robin order, computes in the accept cycle and holds the result in a single-entry output register with valid/ready backpressure. The response is tagged with the requester ID.
- Throughput is one operation per cycle while the consumer keeps `rsp_ready` high.

## Interface
- `WIDTH`, default 64: operand magnitude width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req0_valid` in 1: requester 0 has an operation.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req0_op` in 1: 0 = add, 1 = subtract (a − b).
- `req0_a`, `req0_b` in WIDTH: operand magnitudes.
- `req0_a_sign`, `req0_b_sign` in 1: operand signs, 1 = negative.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_a_sign`, `req1_b`, `req1_b_sign`: same as requester 0.
- `rsp_valid` out 1: the result register holds an unconsumed result.
- `rsp_ready` in 1: the consumer accepts the result.
- `rsp_id` out 1: index of the requester that issued this result.
- `rsp_result` out WIDTH+1: result magnitude.
- `rsp_sign` out 1: result sign.

## Operation
- **Reset values:**
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_result` = 0, `rsp_sign` = 0.
  - The last-grant pointer is set to 1, so requester 0 wins the first contention.
  - `req0_ready` and `req1_ready` are 0 while `rst` is high.
- **Accept condition:** `can_accept` = !`rsp_valid` | `rsp_ready`. The slot is empty or is being drained this cycle.
- **Grant selection:**
  - Only req0 valid → grant 0.
  - Only req1 valid → grant 1.
  - Both valid → grant the requester not equal to the last-grant pointer.
- **Ready outputs:** `reqN_ready` = `can_accept` & grant_N. At most one ready is high per cycle, and `ready` is never high without its `valid`.
- **On accept (valid & ready at a rising edge):**
  - Load the result register with the computed magnitude and sign.
  - Set `rsp_id` = N and `rsp_valid` = 1.
  - Update the last-grant pointer to N.
  - The pointer changes only on an accept.
- **On drain without accept:** `rsp_valid` & `rsp_ready` with no new accept clears `rsp_valid`.
- **Stall:** while `rsp_valid` & !`rsp_ready`, the register contents are held stable and no requester is granted.
- **Arithmetic:**
  - Signed operands: sa = a_sign ? −a : a, sb likewise, evaluated exactly in WIDTH+2 bits.
  - r = op ? sa − sb : sa + sb.
  - `rsp_sign` = (r < 0); `rsp_result` = |r| truncated to WIDTH+1 bits.
  - A zero result always has sign 0; there is no negative zero.
- **Exclusivity:** the datapath is a single shared instance, muxed by the grant. No operation is dropped or duplicated.
- **Fairness:** a requester holding valid high is accepted within 2 accepts of the slot becoming available.

## Timing
- **Latency:** an operation accepted at edge k has `rsp_valid` = 1 with its result after edge k.
- **Back-to-back:** a new accept and a drain in the same cycle both happen. `rsp_valid` stays 1 with the new data, giving full rate.
- **Combinational paths:**
  - `reqN_ready` depends combinationally on `rsp_ready`, `req0_valid`, `req1_valid` and state.
  - Requesters must not make `valid` depend on `ready`.
- **Requester rules:** once `valid` is asserted, the requester holds `valid` and its operands stable until accepted.
- **Reset mid-operation:**
  - Asserting `rst` clears `rsp_valid` and the pointer immediately (asynchronous), discarding any held result.
  - Outputs stay at their reset values until the first rising edge after `rst` deasserts.
- **Output stability:** `rsp_*` outputs come from registers only and carry no combinational path from inputs.

## Test plan
- **Single add (WIDTH=8):** req0 a=5+, b=3+, op=0 → `req0_ready` high in the same cycle; one cycle later `rsp_valid`=1, `rsp_result`=8, `rsp_sign`=0, `rsp_id`=0.
- **Carry and sign cases (WIDTH=8):**
  - req1 a=200+, b=100+, add → `rsp_result`=300 (bit 8 set), `rsp_sign`=0, `rsp_id`=1.
  - a=3+, b=10+, subtract → 7, sign 1.
  - a=4−, b=4+, add → 0, sign 0.
- **Contention:** both requesters valid continuously, `rsp_ready`=1, starting after reset → accepts alternate 0,1,0,1. There is one response per cycle, and `rsp_id` sequence 0,1,0,1 matches the operands.
- **Backpressure:** hold `rsp_ready`=0 for 3 cycles with both requesters valid.
  - During the stall, `rsp_*` stay stable and both `req_ready` signals are 0.
  - In the cycle `rsp_ready` rises, the next requester is granted in that same cycle and there is no bubble.
- **Reset mid-operation:** assert `rst` asynchronously while `rsp_valid`=1 → `rsp_valid` drops before the next edge. After release, with both requesters valid, req0 is granted first.
- **Random soak:** random valids, operands and `rsp_ready` on both ports, checked against an exact reference model. Results must be in order, with no loss and no duplication, and each requester's wait bounded by 2 accepts.

Source files
------------

// File: rtl/fpu_alu_arbiter_if.sv
// Handshake bundle between two add/subtract requesters, the shared-datapath arbiter and the result consumer.
interface fpu_alu_arbiter_if #(parameter int WIDTH = 64);
  logic             req0_valid, req0_ready, req0_op, req0_a_sign, req0_b_sign;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_op, req1_a_sign, req1_b_sign;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_sign;
  logic [WIDTH:0]   rsp_result;

  modport master (
    output req0_valid, req0_op, req0_a, req0_a_sign, req0_b, req0_b_sign,
    output req1_valid, req1_op, req1_a, req1_a_sign, req1_b, req1_b_sign,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_sign
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_a_sign, req0_b, req0_b_sign,
    input  req1_valid, req1_op, req1_a, req1_a_sign, req1_b, req1_b_sign,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_sign
  );
endinterface

// File: rtl/fpu_alu_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude add/subtract datapath between two requesters,
// with a single-entry registered result slot tagged by requester ID.
module fpu_alu_arbiter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  fpu_alu_arbiter_if.slave bus
);

  logic             last_q, last_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_sign_q, rsp_sign_d;
  logic [WIDTH:0]   rsp_result_q, rsp_result_d;

  logic             can_accept, grant0, grant1, ready0, ready1, accept;
  logic             op_sel, a_sign_sel, b_sign_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic signed [WIDTH+1:0] sa, sb, r;
  logic [WIDTH+1:0] r_mag;
  logic             res_sign;
  logic [WIDTH:0]   res_mag;

  // Grant/ready decode: the slot may take a new op when empty or being drained this cycle.
  always_comb begin
    can_accept = !rsp_valid_q || bus.rsp_ready;
    grant0     = bus.req0_valid && (!bus.req1_valid || last_q);
    grant1     = bus.req1_valid && (!bus.req0_valid || !last_q);
    ready0     = !rst && can_accept && grant0;
    ready1     = !rst && can_accept && grant1;
    accept     = ready0 || ready1;
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    op_sel     = bus.req0_op;
    a_sel      = bus.req0_a;
    a_sign_sel = bus.req0_a_sign;
    b_sel      = bus.req0_b;
    b_sign_sel = bus.req0_b_sign;
    if (grant1) begin
      op_sel     = bus.req1_op;
      a_sel      = bus.req1_a;
      a_sign_sel = bus.req1_a_sign;
      b_sel      = bus.req1_b;
      b_sign_sel = bus.req1_b_sign;
    end

    // Two guard bits keep a +/- sum of two WIDTH-bit magnitudes exact.
    sa = {2'b00, a_sel};
    sb = {2'b00, b_sel};
    if (a_sign_sel) sa = -sa;
    if (b_sign_sel) sb = -sb;
    r        = op_sel ? (sa - sb) : (sa + sb);
    res_sign = r[WIDTH+1];
    r_mag    = res_sign ? -r : r;
    res_mag  = r_mag[WIDTH:0];
  end

  always_comb begin
    last_d       = last_q;
    rsp_valid_d  = rsp_valid_q && !bus.rsp_ready;
    rsp_id_d     = rsp_id_q;
    rsp_sign_d   = rsp_sign_q;
    rsp_result_d = rsp_result_q;
    if (accept) begin
      last_d       = grant1;
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant1;
      rsp_sign_d   = res_sign;
      rsp_result_d = res_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q       <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_sign_q   <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      last_q       <= last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sign_q   <= rsp_sign_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sign   = rsp_sign_q;
  assign bus.rsp_result = rsp_result_q;

endmodule

// File: tb/tb_fpu_alu_arbiter.sv
// Directed and randomised checks of fpu_alu_arbiter at WIDTH=8: arithmetic, round-robin grant,
// backpressure, asynchronous reset and fairness.
module tb_fpu_alu_arbiter;
  localparam int W = 8;

  logic clk, rst;
  int   vectors = 0;
  int   miscompares = 0;

  fpu_alu_arbiter_if #(.WIDTH(W)) bus ();
  fpu_alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {rsp_valid, rsp_id, rsp_sign, rsp_result}
  function automatic logic [W+3:0] rsp_tuple();
    return {bus.rsp_valid, bus.rsp_id, bus.rsp_sign, bus.rsp_result};
  endfunction

  function automatic logic [1:0] readies();
    return {bus.req1_ready, bus.req0_ready};
  endfunction

  function automatic void ref_op(input logic op, input int a, input logic as, input int b,
                                 input logic bs, output logic [W:0] mag, output logic sg);
    int sa, sb, r;
    sa  = as ? -a : a;
    sb  = bs ? -b : b;
    r   = op ? sa - sb : sa + sb;
    sg  = (r < 0);
    mag = (W+1)'(r < 0 ? -r : r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic op, input int a, input logic as,
                       input int b, input logic bs);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a[W-1:0]; bus.req0_a_sign = as;
      bus.req0_b = b[W-1:0]; bus.req0_b_sign = bs;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a[W-1:0]; bus.req1_a_sign = as;
      bus.req1_b = b[W-1:0]; bus.req1_b_sign = bs;
    end
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+3:0] got;
    rst = 1'b1;
    drive(0, 1, 0, 1, 0, 1, 0);
    drive(1, 1, 0, 2, 0, 2, 0);
    bus.rsp_ready = 1'b1;
    #3;
    vectors++;
    if (readies() !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready got=%b exp=00", readies());
    end
    got = rsp_tuple();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp got=%h exp=0", got);
    end
    idle();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // Issue one op on a single requester with rsp_ready high; check same-cycle ready and next-cycle result.
  task automatic run_single(input string name, input int n, input logic op, input int a, input logic as,
                            input int b, input logic bs, input int exp_mag, input logic exp_sign);
    logic [W+3:0] exp_t, got;
    logic [1:0]   exp_r;
    drive(n, 1, op, a, as, b, bs);
    bus.rsp_ready = 1'b1;
    #1;
    exp_r = (n == 0) ? 2'b01 : 2'b10;
    vectors++;
    if (readies() !== exp_r) begin
      miscompares++;
      $display("FAIL %s_ready got=%b exp=%b", name, readies(), exp_r);
    end
    step();
    idle();
    exp_t = {1'b1, n[0], exp_sign, exp_mag[W:0]};
    got   = rsp_tuple();
    vectors++;
    if (got !== exp_t) begin
      miscompares++;
      $display("FAIL %s_rsp got=%h exp=%h", name, got, exp_t);
    end
  endtask

  task automatic check_drained(input string name);
    step();
    vectors++;
    if (bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain rsp_valid got=%b exp=0", name, bus.rsp_valid);
    end
  endtask

  task automatic test_single_add();
    run_single("single_add", 0, 0, 5, 0, 3, 0, 8, 0);
    check_drained("single_add");
  endtask

  task automatic test_carry_sign();
    run_single("carry", 1, 0, 200, 0, 100, 0, 300, 0);
    run_single("sub_neg", 0, 1, 3, 0, 10, 0, 7, 1);
    run_single("zero", 1, 0, 4, 1, 4, 0, 0, 0);
    run_single("neg_sub_neg", 0, 1, 255, 1, 255, 0, 510, 1);
    check_drained("carry_sign");
  endtask

  // req0: 10+1=11, req1: 20-2=18; pointer starts at 1 so req0 wins first.
  task automatic test_contention();
    logic [W+3:0] exp_t, got;
    logic [1:0]   exp_r;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    drive(0, 1, 0, 10, 0, 1, 0);
    drive(1, 1, 1, 20, 0, 2, 0);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if (readies() !== exp_r) begin
        miscompares++;
        $display("FAIL contention_ready[%0d] got=%b exp=%b", i, readies(), exp_r);
      end
      step();
      exp_t = (i % 2 == 0) ? {1'b1, 1'b0, 1'b0, 9'd11} : {1'b1, 1'b1, 1'b0, 9'd18};
      got   = rsp_tuple();
      vectors++;
      if (got !== exp_t) begin
        miscompares++;
        $display("FAIL contention_rsp[%0d] got=%h exp=%h", i, got, exp_t);
      end
    end
  endtask

  // Continues from contention: slot holds req1's 18, pointer = 1, both still valid.
  task automatic test_backpressure();
    logic [W+3:0] exp_t, got;
    bus.rsp_ready = 1'b0;
    exp_t = {1'b1, 1'b1, 1'b0, 9'd18};
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (readies() !== 2'b00) begin
        miscompares++;
        $display("FAIL stall_ready[%0d] got=%b exp=00", i, readies());
      end
      step();
      got = rsp_tuple();
      vectors++;
      if (got !== exp_t) begin
        miscompares++;
        $display("FAIL stall_rsp[%0d] got=%h exp=%h", i, got, exp_t);
      end
    end
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if (readies() !== 2'b01) begin
      miscompares++;
      $display("FAIL release_ready got=%b exp=01", readies());
    end
    step();
    idle();
    exp_t = {1'b1, 1'b0, 1'b0, 9'd11};
    got   = rsp_tuple();
    vectors++;
    if (got !== exp_t) begin
      miscompares++;
      $display("FAIL release_rsp got=%h exp=%h", got, exp_t);
    end
    check_drained("backpressure");
  endtask

  task automatic test_reset_mid();
    logic [W+3:0] exp_t, got;
    // Pointer is 0 now; load 50 + (-25) = 25 from req1 and hold it.
    run_single("pre_reset", 1, 0, 50, 0, 25, 1, 25, 0);
    bus.rsp_ready = 1'b0;
    drive(0, 1, 0, 10, 0, 1, 0);
    drive(1, 1, 1, 20, 0, 2, 0);
    rst = 1'b1;
    #1;
    got = rsp_tuple();
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL async_reset_rsp got=%h exp=0", got);
    end
    vectors++;
    if (readies() !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset_ready got=%b exp=00", readies());
    end
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    vectors++;
    if (readies() !== 2'b01) begin
      miscompares++;
      $display("FAIL post_reset_ready got=%b exp=01", readies());
    end
    step();
    exp_t = {1'b1, 1'b0, 1'b0, 9'd11};
    got   = rsp_tuple();
    vectors++;
    if (got !== exp_t) begin
      miscompares++;
      $display("FAIL post_reset_rsp got=%h exp=%h", got, exp_t);
    end
    idle();
    check_drained("reset_mid");
  endtask

  task automatic test_random_soak();
    logic         pend[2];
    logic         p_op[2], p_as[2], p_bs[2];
    int           p_a[2], p_b[2];
    int           wait_cnt[2];
    logic         m_valid, m_id, m_sign, m_last;
    logic [W:0]   m_res;
    logic         can, g0, g1, acc0, acc1;
    logic [1:0]   exp_r;
    logic [W+3:0] exp_t, got;
    int           n;

    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_valid = 0; m_id = 0; m_sign = 0; m_res = '0; m_last = 1;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; wait_cnt[k] = 0;
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1;
          p_op[k] = 1'($urandom_range(0, 1));
          p_as[k] = 1'($urandom_range(0, 1));
          p_bs[k] = 1'($urandom_range(0, 1));
          p_a[k]  = $urandom_range(0, 255);
          p_b[k]  = $urandom_range(0, 255);
        end
        drive(k, pend[k], p_op[k], p_a[k], p_as[k], p_b[k], p_bs[k]);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;

      can   = !m_valid || bus.rsp_ready;
      g0    = pend[0] && (!pend[1] || m_last);
      g1    = pend[1] && (!pend[0] || !m_last);
      exp_r = {can && g1, can && g0};
      vectors++;
      if (readies() !== exp_r) begin
        miscompares++;
        $display("FAIL soak_ready[%0d] got=%b exp=%b", cyc, readies(), exp_r);
      end

      acc0 = bus.req0_ready && pend[0];
      acc1 = bus.req1_ready && pend[1];
      if (acc1 && pend[0]) begin
        wait_cnt[0]++;
        vectors++;
        if (wait_cnt[0] > 2) begin
          miscompares++;
          $display("FAIL soak_fair0[%0d] waited=%0d limit=2", cyc, wait_cnt[0]);
        end
      end
      if (acc0 && pend[1]) begin
        wait_cnt[1]++;
        vectors++;
        if (wait_cnt[1] > 2) begin
          miscompares++;
          $display("FAIL soak_fair1[%0d] waited=%0d limit=2", cyc, wait_cnt[1]);
        end
      end
      if (acc0) wait_cnt[0] = 0;
      if (acc1) wait_cnt[1] = 0;

      if (can && (g0 || g1)) begin
        n = g1 ? 1 : 0;
        ref_op(p_op[n], p_a[n], p_as[n], p_b[n], p_bs[n], m_res, m_sign);
        m_valid = 1;
        m_id    = n[0];
        m_last  = n[0];
        pend[n] = 0;
      end else if (bus.rsp_ready) begin
        m_valid = 0;
      end

      step();
      got = rsp_tuple();
      if (m_valid) begin
        exp_t = {1'b1, m_id, m_sign, m_res};
        vectors++;
        if (got !== exp_t) begin
          miscompares++;
          $display("FAIL soak_rsp[%0d] got=%h exp=%h", cyc, got, exp_t);
        end
      end else begin
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL soak_valid[%0d] got=%b exp=0", cyc, bus.rsp_valid);
        end
      end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_single_add();
    test_carry_sign();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random_soak();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
